// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared types and constants for the PS/2 key event controller.
//             Holds the decoder state enum, the 10-bit event record, the
//             scan-code prefix bytes and the codes of the tracked keys.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Decoder states: which prefix bytes have been seen for the current key.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  // Event record as presented on EV_DATA: {ext, rel, code[7:0]}.
  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_event_t;

  // Prefix bytes of the scan-code set 2 protocol.
  localparam logic [7:0] c_pfx_ext   = 8'hE0;
  localparam logic [7:0] c_pfx_brk   = 8'hF0;
  localparam logic [7:0] c_pfx_pause = 8'hE1;

  // Tracked keys. The first four are extended codes (E0-prefixed),
  // jump is a plain code.
  localparam logic [7:0] c_key_up    = 8'h75;
  localparam logic [7:0] c_key_down  = 8'h72;
  localparam logic [7:0] c_key_left  = 8'h6B;
  localparam logic [7:0] c_key_right = 8'h74;
  localparam logic [7:0] c_key_jump  = 8'h29;

  localparam int c_num_keys = 5;

  // One-hot KEYS mask for a decoded key: bit order {jump,right,left,down,up}.
  // Returns zero for keys that are not tracked.
  function automatic logic [c_num_keys-1:0] key_mask(input logic       ext,
                                                     input logic [7:0] code);
    logic [c_num_keys-1:0] m;
    m = '0;
    if (ext) begin
      case (code)
        c_key_up:    m[0] = 1'b1;
        c_key_down:  m[1] = 1'b1;
        c_key_left:  m[2] = 1'b1;
        c_key_right: m[3] = 1'b1;
        default:     m    = '0;
      endcase
    end else if (code == c_key_jump) begin
      m[4] = 1'b1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_event_fifo
//  Purpose  : Show-ahead event FIFO. The head entry is always presented on
//             data_o; a pop advances it. Push and pop may happen on the same
//             edge, including while full (the slot being vacated is reused).
//  Ports    : clk_i    - system clock, rising edge
//             rst_ni   - asynchronous active-low reset
//             push_i   - write data_i this edge
//             data_i   - event to write
//             pop_i    - consumer pop request (ignored while empty)
//             data_o   - head entry, zero while empty
//             empty_o  - no entries held
//             full_o   - DEPTH entries held
//             drop_o   - push refused this cycle (full and no pop)
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  ps2_event_t data_i,
  input  logic       pop_i,
  output ps2_event_t data_o,
  output logic       empty_o,
  output logic       full_o,
  output logic       drop_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  ps2_event_t    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (cnt_q == '0);
  assign w_full    = (cnt_q == CW'(DEPTH));
  assign w_do_pop  = pop_i && !w_empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_do_push = push_i && (!w_full || w_do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (w_do_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (w_do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({w_do_push, w_do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: data_o is masked while empty.
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = w_empty ? '0 : mem_q[rd_ptr_q];
  assign empty_o = w_empty;
  assign full_o  = w_full;
  assign drop_o  = push_i && !w_do_push;

endmodule
`default_nettype wire

// File: rtl/ps2_key_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_event_ctrl
//  Purpose  : Turns a stream of PS/2 scan-code bytes into make/break events,
//             buffers them in a show-ahead FIFO and tracks the held state of
//             five game keys. A prefix byte left without its follow-up for
//             TIMEOUT_CYCLES clocks is abandoned.
//  Config   : PS2_TYPEMATIC_FILTER_EN - when defined, repeated make events of
//             a tracked key that is already held are not pushed.
//  Ports    : CLK        - system clock, rising edge
//             RST_N      - asynchronous active-low reset
//             CODE_VALID - one-cycle strobe, byte on CODE complete
//             CODE       - received scan-code byte
//             RD_EN      - pop the FIFO head
//             CLR_OVF    - clear sticky OVERFLOW
//             EV_DATA    - FIFO head {ext, rel, code}
//             EMPTY      - FIFO empty
//             FULL       - FIFO full
//             OVERFLOW   - sticky, an event was dropped
//             KEYS       - held keys {jump, right, left, down, up}
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_key_event_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CODE_VALID,
  input  logic [7:0]            CODE,
  input  logic                  RD_EN,
  input  logic                  CLR_OVF,
  output logic [9:0]            EV_DATA,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  OVERFLOW,
  output logic [c_num_keys-1:0] KEYS
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_e            state_q, state_d;
  logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic [c_num_keys-1:0] keys_q, keys_d;
  logic                  ovf_q, ovf_d;

  logic                  w_ev_vld;
  ps2_event_t            w_ev;
  logic [c_num_keys-1:0] w_key_mask;
  logic                  w_push;
  logic                  w_drop;
  ps2_event_t            w_head;

  // --------------------------------------------------------------------------
  // Prefix decoder and timeout counter
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    w_ev_vld  = 1'b0;
    w_ev      = '0;

    if (CODE_VALID) begin
      tmo_cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (CODE == c_pfx_ext) begin
            state_d = ST_EXT;
          end else if (CODE == c_pfx_brk) begin
            state_d = ST_BRK;
          end else if (CODE != c_pfx_pause) begin
            // E1 (pause sequence lead-in) is swallowed without an event.
            w_ev_vld = 1'b1;
            w_ev     = '{ext: 1'b0, rel: 1'b0, code: CODE};
          end
        end
        ST_EXT: begin
          if (CODE == c_pfx_brk) begin
            state_d = ST_EXT_BRK;
          end else if (CODE != c_pfx_ext) begin
            w_ev_vld = 1'b1;
            w_ev     = '{ext: 1'b1, rel: 1'b0, code: CODE};
            state_d  = ST_IDLE;
          end
        end
        ST_BRK: begin
          w_ev_vld = 1'b1;
          w_ev     = '{ext: 1'b0, rel: 1'b1, code: CODE};
          state_d  = ST_IDLE;
        end
        ST_EXT_BRK: begin
          w_ev_vld = 1'b1;
          w_ev     = '{ext: 1'b1, rel: 1'b1, code: CODE};
          state_d  = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      // The edge that would bring the count to TIMEOUT_CYCLES abandons the
      // prefix instead.
      if (tmo_cnt_q >= TW'(TIMEOUT_CYCLES - 1)) begin
        state_d   = ST_IDLE;
        tmo_cnt_d = '0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
      end
    end else begin
      tmo_cnt_d = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Held-key tracking and push qualification
  // --------------------------------------------------------------------------
  assign w_key_mask = key_mask(w_ev.ext, w_ev.code);

  always_comb begin
    keys_d = keys_q;
    w_push = w_ev_vld;
    if (w_ev_vld && (w_key_mask != '0)) begin
      if (w_ev.rel) begin
        keys_d = keys_q & ~w_key_mask;
      end else begin
        keys_d = keys_q | w_key_mask;
      end
`ifdef PS2_TYPEMATIC_FILTER_EN
      // Auto-repeat of a key already held carries no new information.
      if (!w_ev.rel && ((keys_q & w_key_mask) != '0)) begin
        w_push = 1'b0;
      end
`endif
    end
  end

  // A fresh drop outranks a clear on the same edge.
  always_comb begin
    ovf_d = ovf_q;
    if (w_drop) begin
      ovf_d = 1'b1;
    end else if (CLR_OVF) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      tmo_cnt_q <= '0;
      keys_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      keys_q    <= keys_d;
      ovf_q     <= ovf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Event FIFO
  // --------------------------------------------------------------------------
  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (w_push),
    .data_i  (w_ev),
    .pop_i   (RD_EN),
    .data_o  (w_head),
    .empty_o (EMPTY),
    .full_o  (FULL),
    .drop_o  (w_drop)
  );

  assign EV_DATA  = w_head;
  assign OVERFLOW = ovf_q;
  assign KEYS     = keys_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_key_event_ctrl
//  Purpose  : Self-checking bench for ps2_key_event_ctrl. Expected events are
//             queued as bytes are sent and compared as the FIFO is drained.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_event_ctrl;

  logic       CLK;
  logic       RST_N;
  logic       CODE_VALID;
  logic [7:0] CODE;
  logic       RD_EN;
  logic       CLR_OVF;
  logic [9:0] EV_DATA;
  logic       EMPTY;
  logic       FULL;
  logic       OVERFLOW;
  logic [4:0] KEYS;

  int n_total;
  int n_bad;

  logic [9:0] sb_q[$];

  ps2_key_event_ctrl #(
    .FIFO_DEPTH     (8),
    .TIMEOUT_CYCLES (50000)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .CODE_VALID (CODE_VALID),
    .CODE       (CODE),
    .RD_EN      (RD_EN),
    .CLR_OVF    (CLR_OVF),
    .EV_DATA    (EV_DATA),
    .EMPTY      (EMPTY),
    .FULL       (FULL),
    .OVERFLOW   (OVERFLOW),
    .KEYS       (KEYS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One byte strobe; inputs change on the falling edge, leaves at a falling edge.
  task automatic send(input logic [7:0] b, input logic rd, input logic clr);
    @(negedge CLK);
    CODE       = b;
    CODE_VALID = 1'b1;
    RD_EN      = rd;
    CLR_OVF    = clr;
    @(negedge CLK);
    CODE_VALID = 1'b0;
    RD_EN      = 1'b0;
    CLR_OVF    = 1'b0;
  endtask

  // Pop everything, comparing each head with the scoreboard.
  task automatic drain(input string tag);
    logic [31:0] exp;
    for (int i = 0; i < 32; i++) begin
      if (EMPTY) break;
      exp = (sb_q.size() != 0) ? {22'd0, sb_q.pop_front()} : 32'hDEAD;
      check({tag, "_ev"}, {22'd0, EV_DATA}, exp);
      RD_EN = 1'b1;
      @(negedge CLK);
      RD_EN = 1'b0;
    end
    check({tag, "_missing"}, sb_q.size(), 0);
    check({tag, "_empty"}, {31'd0, EMPTY}, 1);
    sb_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    n_total    = 0;
    n_bad      = 0;
    RST_N      = 1'b0;
    CODE_VALID = 1'b0;
    CODE       = 8'h00;
    RD_EN      = 1'b0;
    CLR_OVF    = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_empty", {31'd0, EMPTY}, 1);
    check("rst_full", {31'd0, FULL}, 0);
    check("rst_ovf", {31'd0, OVERFLOW}, 0);
    check("rst_keys", {27'd0, KEYS}, 0);
    check("rst_evdata", {22'd0, EV_DATA}, 0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Plain make and break
    send(8'h1D, 0, 0); sb_q.push_back(10'h01D);
    check("make_empty", {31'd0, EMPTY}, 0);
    check("make_keys", {27'd0, KEYS}, 0);
    send(8'hF0, 0, 0);
    send(8'h1D, 0, 0); sb_q.push_back(10'h11D);
    drain("plain");

    // Extended make/break of a tracked key
    send(8'hE0, 0, 0);
    send(8'h74, 0, 0); sb_q.push_back(10'h274);
    check("right_make_keys", {27'd0, KEYS}, 5'b01000);
    send(8'hE0, 0, 0);
    send(8'hF0, 0, 0);
    send(8'h74, 0, 0); sb_q.push_back(10'h374);
    check("right_brk_keys", {27'd0, KEYS}, 0);
    drain("ext");

    // E1 produces nothing; E0 E0 stays extended
    send(8'hE1, 0, 0);
    check("e1_empty", {31'd0, EMPTY}, 1);
    send(8'hE0, 0, 0);
    send(8'hE0, 0, 0);
    send(8'h72, 0, 0); sb_q.push_back(10'h272);
    check("down_keys", {27'd0, KEYS}, 5'b00010);
    send(8'hE0, 0, 0);
    send(8'hF0, 0, 0);
    send(8'h72, 0, 0); sb_q.push_back(10'h372);
    drain("e1e0");

    // Prefix well inside the timeout is still honoured
    send(8'hE0, 0, 0);
    repeat (100) @(negedge CLK);
    send(8'h75, 0, 0); sb_q.push_back(10'h275);
    check("up_keys", {27'd0, KEYS}, 5'b00001);
    send(8'hE0, 0, 0);
    send(8'hF0, 0, 0);
    send(8'h75, 0, 0); sb_q.push_back(10'h375);
    drain("pre_tmo");

    // Prefix abandoned after the timeout
    send(8'hE0, 0, 0);
    repeat (50000) @(negedge CLK);
    check("tmo_empty", {31'd0, EMPTY}, 1);
    send(8'h29, 0, 0); sb_q.push_back(10'h029);
    check("tmo_keys", {27'd0, KEYS}, 5'b10000);
    send(8'hF0, 0, 0);
    send(8'h29, 0, 0); sb_q.push_back(10'h129);
    drain("tmo");

    // Fill to overflow
    for (int i = 0; i < 9; i++) begin
      b = 8'h10 + 8'(i);
      send(b, 0, 0);
      if (i < 8) sb_q.push_back({2'b00, b});
    end
    check("ovf_full", {31'd0, FULL}, 1);
    check("ovf_set", {31'd0, OVERFLOW}, 1);
    check("ovf_head", {22'd0, EV_DATA}, 10'h010);
    @(negedge CLK); CLR_OVF = 1'b1;
    @(negedge CLK); CLR_OVF = 1'b0;
    check("ovf_clr", {31'd0, OVERFLOW}, 0);
    // Push while full with a pop is accepted
    check("full_rd_head", {22'd0, EV_DATA}, {22'd0, sb_q[0]});
    send(8'h20, 1, 0);
    void'(sb_q.pop_front());
    sb_q.push_back(10'h020);
    check("full_rd_full", {31'd0, FULL}, 1);
    check("full_rd_ovf", {31'd0, OVERFLOW}, 0);
    // New drop beats a simultaneous clear
    send(8'h21, 0, 1);
    check("ovf_vs_clr", {31'd0, OVERFLOW}, 1);
    @(negedge CLK); CLR_OVF = 1'b1;
    @(negedge CLK); CLR_OVF = 1'b0;
    check("ovf_clr2", {31'd0, OVERFLOW}, 0);
    drain("ovf");

    // Push into empty with RD_EN must not pop
    send(8'h33, 1, 0); sb_q.push_back(10'h033);
    check("push_empty_rd", {31'd0, EMPTY}, 0);
    drain("empty_rd");

    // Simultaneous push/pop keeps occupancy
    send(8'h34, 0, 0);
    check("pp_head", {22'd0, EV_DATA}, 10'h034);
    send(8'h35, 1, 0); sb_q.push_back(10'h035);
    drain("pushpop");

    // Typematic repeats
    send(8'h29, 0, 0); sb_q.push_back(10'h029);
    send(8'h29, 0, 0);
`ifndef PS2_TYPEMATIC_FILTER_EN
    sb_q.push_back(10'h029);
`endif
    send(8'h29, 0, 0);
`ifndef PS2_TYPEMATIC_FILTER_EN
    sb_q.push_back(10'h029);
`endif
    check("rep_keys", {27'd0, KEYS}, 5'b10000);
    send(8'hF0, 0, 0);
    send(8'h29, 0, 0); sb_q.push_back(10'h129);
    drain("repeat");

    // Reset in the middle of E0 F0
    send(8'h29, 0, 0);
    send(8'hE0, 0, 0);
    send(8'hF0, 0, 0);
    check("prerst_empty", {31'd0, EMPTY}, 0);
    #3 RST_N = 1'b0;
    #4;
    check("midrst_empty", {31'd0, EMPTY}, 1);
    check("midrst_keys", {27'd0, KEYS}, 0);
    check("midrst_ev", {22'd0, EV_DATA}, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    send(8'h75, 0, 0); sb_q.push_back(10'h075);
    check("postrst_keys", {27'd0, KEYS}, 0);
    check("postrst_empty", {31'd0, EMPTY}, 0);
    drain("postrst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
